// File: rtl/cnn_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_stream_pkg
// Description : Shared types and helpers for the CNN image streaming blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_stream_pkg;

    // Read-side sequencing of one frame.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } stream_state_t;

    // Width needed for a counter that runs 0..n-1. Never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/image_stream_source_if.sv
`default_nettype none
// ============================================================================
// Module      : image_stream_source_if
// Description : Write port, pixel stream and downstream control signals of
//               image_stream_source.
// Revision    : 1.0 - initial release
// ============================================================================
interface image_stream_source_if #(
    parameter int BitSize = 32
);
    logic               wr_valid;
    logic [BitSize-1:0] wr_data;
    logic               wr_ready;
    logic               out_ready;
    logic               out_valid;
    logic [BitSize-1:0] out_data;
    logic               out_last;
    logic               conv_clear;
    logic               down_done;
    logic               frame_done;

    // The frame source itself.
    modport master (
        input  wr_valid, wr_data, out_ready, down_done,
        output wr_ready, out_valid, out_data, out_last, conv_clear, frame_done
    );

    // The writer / downstream consumer side.
    modport slave (
        output wr_valid, wr_data, out_ready, down_done,
        input  wr_ready, out_valid, out_data, out_last, conv_clear, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/image_stream_source_frame_bank.sv
`default_nettype none
// ============================================================================
// Module      : frame_bank
// Description : One image bank: registered pixel array with a single write
//               port and a combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_bank #(
    parameter int BitSize = 32,
    parameter int Depth   = 16,
    parameter int AddrW   = 4
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AddrW-1:0]   waddr,
    input  logic [BitSize-1:0] wdata,
    input  logic [AddrW-1:0]   raddr,
    output logic [BitSize-1:0] rdata
);

    logic [BitSize-1:0] mem [Depth];

    // Pixel storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/image_stream_source.sv
`default_nettype none
// ============================================================================
// Module      : image_stream_source
// Description : Ping-pong frame buffer that accepts whole images on a write
//               port and streams them in raster order to convolution_buffer,
//               with a clear pulse before and a drain handshake after each.
// Revision    : 1.0 - initial release
// ============================================================================
module image_stream_source
    import cnn_stream_pkg::*;
#(
    parameter int BitSize     = 32,
    parameter int ImageWidth  = 4,
    parameter int ImageHeight = ImageWidth
) (
    input  logic                  clk,
    input  logic                  res_n,
    image_stream_source_if.master bus
);

    localparam int FrameSize = ImageWidth * ImageHeight;
    localparam int CntW      = cnt_width(FrameSize);
    localparam logic [CntW-1:0] LastIdx = CntW'(FrameSize - 1);

    stream_state_t      state;
    logic               wr_bank;
    logic               rd_bank;
    logic [CntW-1:0]    wr_cnt;
    logic [CntW-1:0]    rd_cnt;
    logic [1:0]         full;
    logic [1:0]         full_nxt;
    logic               wr_fire;
    logic               rd_fire;
    logic [BitSize-1:0] bank_rdata [2];

    assign wr_fire = bus.wr_valid && !full[wr_bank];
    assign rd_fire = (state == STREAM) && bus.out_ready;

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            frame_bank #(
                .BitSize (BitSize),
                .Depth   (FrameSize),
                .AddrW   (CntW)
            ) u_bank (
                .clk   (clk),
                .we    (wr_fire && (wr_bank == 1'(b))),
                .waddr (wr_cnt),
                .wdata (bus.wr_data),
                .raddr (rd_cnt),
                .rdata (bank_rdata[b])
            );
        end
    endgenerate

    // Write pointer: fills the current bank pixel by pixel, then flips banks.
    always_ff @(posedge clk) begin
        if (res_n) begin
            wr_bank <= 1'b0;
            wr_cnt  <= '0;
        end else if (wr_fire) begin
            if (wr_cnt == LastIdx) begin
                wr_cnt  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    // Release and fill always target different banks, so both may apply at once.
    always_comb begin
        full_nxt = full;
        if (rd_fire && (rd_cnt == LastIdx)) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (wr_fire && (wr_cnt == LastIdx)) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    // Bank occupancy flags.
    always_ff @(posedge clk) begin
        if (res_n) begin
            full <= 2'b00;
        end else begin
            full <= full_nxt;
        end
    end

    // Read sequencer: clear downstream, stream one frame, wait for its drain.
    always_ff @(posedge clk) begin
        if (res_n) begin
            state   <= IDLE;
            rd_bank <= 1'b0;
            rd_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (full[rd_bank]) begin
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    rd_cnt <= '0;
                    state  <= STREAM;
                end
                STREAM: begin
                    if (bus.out_ready) begin
                        if (rd_cnt == LastIdx) begin
                            rd_cnt  <= '0;
                            rd_bank <= ~rd_bank;
                            state   <= DRAIN;
                        end else begin
                            rd_cnt <= rd_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.down_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.wr_ready   = !full[wr_bank];
    assign bus.out_valid  = (state == STREAM);
    assign bus.out_data   = (state == STREAM) ? bank_rdata[rd_bank] : '0;
    assign bus.out_last   = (state == STREAM) && (rd_cnt == LastIdx);
    assign bus.conv_clear = (state == CLEAR);
    assign bus.frame_done = (state == DRAIN) && bus.down_done;

endmodule
`default_nettype wire

// File: tb/tb_image_stream_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_stream_source
// Description : Self-checking bench for image_stream_source: cycle tables,
//               hand-written corner sequences and randomized frames checked
//               against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_stream_source;

    localparam int BW = 32;
    localparam int IW = 4;
    localparam int FS = IW * IW;

    logic clk   = 1'b0;
    logic res_n = 1'b1;

    always #5 clk = ~clk;

    image_stream_source_if #(.BitSize(BW)) bus ();

    image_stream_source #(
        .BitSize     (BW),
        .ImageWidth  (IW),
        .ImageHeight (IW)
    ) dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-level reference model: complete frames queue up as pixel lists,
    // at most two may be held, each is streamed after one clear and must be
    // followed by a drain handshake.
    // ------------------------------------------------------------------
    logic [31:0] part[$];
    logic [31:0] exp_px[$];
    int          pending;
    int          rd_idx;
    int          frames_done;
    bit          streaming, in_drain, cleared;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;

    // Sample away from the active edge and score every cycle.
    always @(negedge clk) begin
        if (res_n) begin
            part.delete();
            exp_px.delete();
            pending = 0; rd_idx = 0; frames_done = 0;
            streaming = 0; in_drain = 0; cleared = 0; prev_stall = 0;
        end else begin
            check("m_wr_ready", 32'(bus.wr_ready), 32'(pending < 2));
            check("m_out_valid", 32'(bus.out_valid), 32'(streaming));
            check("m_frame_done", 32'(bus.frame_done), 32'(in_drain && bus.down_done));
            if (prev_stall) begin
                check("m_stall_data", bus.out_data, prev_data);
                check("m_stall_last", 32'(bus.out_last), 32'(prev_last));
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            if (in_drain && bus.down_done) begin
                in_drain = 0;
                frames_done++;
            end
            if (bus.conv_clear) begin
                check("m_clear_cond", 32'(!streaming && !in_drain && pending > 0), 32'd1);
                streaming = 1;
                cleared   = 1;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_px.size() == 0) begin
                    check("m_px_avail", 32'd0, 32'd1);
                end else begin
                    if (rd_idx == 0) begin
                        check("m_clear_first", 32'(cleared), 32'd1);
                        cleared = 0;
                    end
                    check("m_out_data", bus.out_data, exp_px.pop_front());
                    check("m_out_last", 32'(bus.out_last), 32'(rd_idx == FS - 1));
                    rd_idx++;
                    if (rd_idx == FS) begin
                        rd_idx = 0; pending--; streaming = 0; in_drain = 1;
                    end
                end
            end
            if (bus.wr_valid && bus.wr_ready) begin
                part.push_back(bus.wr_data);
                if (part.size() == FS) begin
                    foreach (part[i]) exp_px.push_back(part[i]);
                    part.delete();
                    pending++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Cycle tables
    // ------------------------------------------------------------------
    typedef struct {
        logic        wv;
        logic [31:0] wd;
        logic        ordy;
        logic        dd;
        logic        ov;
        logic [31:0] od;
        logic        ol;
        logic        cc;
        logic        fd;
        logic        wr;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.out_ready = 1'b1;
        bus.down_done = 1'b0;
    endtask

    task automatic do_reset();
        res_n = 1'b1;
        idle_inputs();
        tick();
        tick();
        res_n = 1'b0;
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[i]) begin
            bus.wr_valid  = tbl[i].wv;
            bus.wr_data   = tbl[i].wd;
            bus.out_ready = tbl[i].ordy;
            bus.down_done = tbl[i].dd;
            @(negedge clk);
            check({tag, "_out_valid"},  32'(bus.out_valid),  32'(tbl[i].ov));
            check({tag, "_out_data"},   bus.out_data,        tbl[i].od);
            check({tag, "_out_last"},   32'(bus.out_last),   32'(tbl[i].ol));
            check({tag, "_conv_clear"}, 32'(bus.conv_clear), 32'(tbl[i].cc));
            check({tag, "_frame_done"}, 32'(bus.frame_done), 32'(tbl[i].fd));
            check({tag, "_wr_ready"},   32'(bus.wr_ready),   32'(tbl[i].wr));
            tick();
        end
        idle_inputs();
    endtask

    task automatic write_frame(input logic [31:0] base);
        for (int i = 0; i < FS; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = base + 32'(i);
            tick();
        end
        bus.wr_valid = 1'b0;
    endtask

    // Returns positioned at the negedge where the pixel is presented.
    task automatic wait_px(input logic [31:0] val, input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!(bus.out_valid && bus.out_data == val) && k < 200) begin
            tick();
            @(negedge clk);
            k++;
        end
        check(name, 32'(bus.out_valid && bus.out_data == val), 32'd1);
    endtask

    // From the negedge of the last transfer: drain immediately.
    task automatic finish_frame(input string name);
        tick();
        bus.down_done = 1'b1;
        @(negedge clk);
        check(name, 32'(bus.frame_done), 32'd1);
        tick();
        bus.down_done = 1'b0;
    endtask

    vec_t        v;
    logic [31:0] wq[$];
    int          budget;

    initial begin
        idle_inputs();

        // ---- reset values ----
        do_reset();
        @(negedge clk);
        check("rst_wr_ready",   32'(bus.wr_ready),   32'd1);
        check("rst_out_valid",  32'(bus.out_valid),  32'd0);
        check("rst_out_last",   32'(bus.out_last),   32'd0);
        check("rst_conv_clear", 32'(bus.conv_clear), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check("rst_out_data",   bus.out_data,        32'd0);
        tick();

        // ---- single frame, full rate, drain 3 cycles after last pixel ----
        do_reset();
        tbl.delete();
        for (int c = 0; c < 38; c++) begin
            v.wv = (c < 16);  v.wd = (c < 16) ? 32'(c + 1) : 32'd0;
            v.ordy = 1'b1;    v.dd = (c == 36);
            v.ov = (c >= 18 && c <= 33);
            v.od = v.ov ? 32'(c - 17) : 32'd0;
            v.ol = (c == 33); v.cc = (c == 17); v.fd = (c == 36); v.wr = 1'b1;
            tbl.push_back(v);
        end
        run_table("t1");

        // ---- two frames back to back, third write refused while both full ----
        do_reset();
        tbl.delete();
        for (int c = 0; c < 62; c++) begin
            v.wv = (c < 34);
            v.wd = (c < 16) ? 32'(c + 1) : (c < 32) ? 32'(101 + c - 16) : 32'd999;
            v.ordy = 1'b1;  v.dd = (c == 40 || c == 60);
            v.ov = (c >= 18 && c <= 33) || (c >= 43 && c <= 58);
            v.od = (c >= 18 && c <= 33) ? 32'(c - 17) : (c >= 43 && c <= 58) ? 32'(101 + c - 43) : 32'd0;
            v.ol = (c == 33 || c == 58); v.cc = (c == 17 || c == 42);
            v.fd = (c == 40 || c == 60); v.wr = !(c == 32 || c == 33);
            tbl.push_back(v);
        end
        run_table("t3");

        // ---- last write of bank 1 coincides with last read of bank 0 ----
        do_reset();
        tbl.delete();
        for (int c = 0; c < 57; c++) begin
            v.wv = (c < 16) || (c >= 18 && c <= 33);
            v.wd = (c < 16) ? 32'(c + 1) : (c >= 18 && c <= 33) ? 32'(101 + c - 18) : 32'd0;
            v.ordy = 1'b1;  v.dd = (c == 36 || c == 55);
            v.ov = (c >= 18 && c <= 33) || (c >= 39 && c <= 54);
            v.od = (c >= 18 && c <= 33) ? 32'(c - 17) : (c >= 39 && c <= 54) ? 32'(101 + c - 39) : 32'd0;
            v.ol = (c == 33 || c == 54); v.cc = (c == 17 || c == 38);
            v.fd = (c == 36 || c == 55); v.wr = 1'b1;
            tbl.push_back(v);
        end
        run_table("t4");

        // ---- backpressure at pixel 7 ----
        do_reset();
        write_frame(32'd1);
        wait_px(32'd6, "stall_reach6");
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_hold7", bus.out_data, 32'd7);
            tick();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("stall_resume7", bus.out_data, 32'd7);
        tick();
        @(negedge clk);
        check("stall_then8", bus.out_data, 32'd8);
        tick();
        wait_px(32'd16, "stall_reach16");
        finish_frame("stall_frame_done");

        // ---- reset in the middle of a stream ----
        do_reset();
        write_frame(32'd1);
        wait_px(32'd9, "mid_reach9");
        tick();
        res_n = 1'b1;
        @(negedge clk);
        tick();
        res_n = 1'b0;
        @(negedge clk);
        check("mid_wr_ready",   32'(bus.wr_ready),   32'd1);
        check("mid_out_valid",  32'(bus.out_valid),  32'd0);
        check("mid_out_last",   32'(bus.out_last),   32'd0);
        check("mid_conv_clear", 32'(bus.conv_clear), 32'd0);
        check("mid_frame_done", 32'(bus.frame_done), 32'd0);
        check("mid_out_data",   bus.out_data,        32'd0);
        tick();
        write_frame(32'd51);
        wait_px(32'd51, "mid_restart_first");
        tick();
        wait_px(32'd66, "mid_restart_last");
        finish_frame("mid_frame_done2");

        // ---- down_done during STREAM is ignored; DRAIN waits for it ----
        do_reset();
        write_frame(32'd1);
        wait_px(32'd3, "dd_reach3");
        tick();
        bus.down_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("dd_stream_fd", 32'(bus.frame_done), 32'd0);
            tick();
        end
        bus.down_done = 1'b0;
        wait_px(32'd16, "dd_reach16");
        tick();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("dd_drain_valid", 32'(bus.out_valid), 32'd0);
            check("dd_drain_fd",    32'(bus.frame_done), 32'd0);
            check("dd_drain_clear", 32'(bus.conv_clear), 32'd0);
            tick();
        end
        bus.down_done = 1'b1;
        @(negedge clk);
        check("dd_late_fd", 32'(bus.frame_done), 32'd1);
        tick();
        bus.down_done = 1'b0;
        @(negedge clk);
        check("dd_after_fd", 32'(bus.frame_done), 32'd0);
        tick();

        // ---- randomized traffic, scored by the reference model ----
        do_reset();
        wq.delete();
        for (int i = 0; i < 5 * FS; i++) wq.push_back($urandom);
        budget = 0;
        while ((wq.size() > 0 || frames_done < 5) && budget < 4000) begin
            bus.wr_valid  = (wq.size() > 0) && ($urandom_range(3) != 0);
            bus.wr_data   = bus.wr_valid ? wq[0] : $urandom;
            bus.out_ready = ($urandom_range(2) != 0);
            bus.down_done = ($urandom_range(3) == 0);
            @(negedge clk);
            if (bus.wr_valid && bus.wr_ready) void'(wq.pop_front());
            tick();
            budget++;
        end
        idle_inputs();
        check("rand_frames_done", 32'(frames_done), 32'd5);
        check("rand_writes_done", 32'(wq.size()), 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/image_stream_source.md
Name: image_stream_source

Overview:
- Frame-level transmitter that feeds convolution_buffer.
- Accepts a whole image on a write port into one of two ping-pong banks, then streams the stored image out in raster order, one pixel per transfer, under valid/ready.
- Generates the one-cycle downstream clear that convolution_buffer needs before each new image.
- Waits for the downstream drain-complete before starting the next frame.

Parameters:
- BitSize, 32, pixel width in bits.
- ImageWidth, 4, pixels per row.
- ImageHeight, ImageWidth, rows per frame.
- FrameSize (localparam), ImageWidth*ImageHeight, pixels per frame.

Ports:
- clk  in  1  single clock, rising edge.
- res_n  in  1  synchronous, active-high reset; 1 resets the block. Name is kept for codebase consistency.
- wr_valid  in  1  write pixel present.
- wr_data  in  BitSize  write pixel, raster order.
- wr_ready  out  1  write bank can accept a pixel.
- out_ready  in  1  downstream accepts a pixel (convolution_buffer out_ready).
- out_valid  out  1  out_data is valid.
- out_data  out  BitSize  streamed pixel.
- out_last  out  1  qualifies the final pixel of the frame.
- conv_clear  out  1  one-cycle downstream clear pulse, issued before the first pixel of each frame.
- down_done  in  1  downstream drain complete (convolution_buffer out_done).
- frame_done  out  1  one-cycle pulse when a frame's streaming and drain have both finished.

Behaviour:
- Reset:
  - wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, full[1:0]=0, FSM=IDLE.
  - Outputs: wr_ready=1, out_valid=0, out_last=0, conv_clear=0, frame_done=0, out_data=0.
  - Reset mid-frame discards both banks and any partial write; no pulse is emitted.
- Write side:
  - wr_ready = !full[wr_bank].
  - A write occurs when wr_valid && wr_ready: bank[wr_bank][wr_cnt] <= wr_data and wr_cnt increments.
  - When wr_cnt==FrameSize-1 on a write: wr_cnt<=0, full[wr_bank]<=1, wr_bank toggles.
  - While the target bank is full, wr_ready=0 and wr_data is ignored.
- Read FSM:
  - IDLE: if full[rd_bank], go to CLEAR.
  - CLEAR: conv_clear=1 for exactly this cycle; rd_cnt=0; go to STREAM.
  - STREAM:
    - out_valid=1; out_data=bank[rd_bank][rd_cnt] (combinational read of a registered array); out_last = (rd_cnt==FrameSize-1).
    - A transfer occurs when out_valid && out_ready; rd_cnt then increments.
    - On the transfer of the last pixel: full[rd_bank]<=0, rd_bank toggles, go to DRAIN.
    - While out_ready=0, out_valid stays 1 and out_data/out_last stay stable.
  - DRAIN: out_valid=0. On down_done=1: frame_done=1 for that cycle, go to IDLE.
- Latency: the bank becomes full at edge T; the FSM is in IDLE during the cycle after T, conv_clear is high the following cycle, and out_valid first asserts one cycle after that, i.e. 2 cycles after the cycle in which full is first visible.
- Simultaneous events:
  - Releasing bank A at the last read in the same cycle as bank B's last write is legal; both flag updates apply.
  - The write side may fill the idle bank during STREAM or DRAIN. Throughput is one pixel per cycle on both sides.
- down_done outside DRAIN is ignored.
- conv_clear is active-high. Downstream inverts it into its active-low reset, combined with the system reset at top level.

Decomposition:
- Shared package cnn_stream_pkg:
  - typedef stream_state_t {IDLE, CLEAR, STREAM, DRAIN}.
  - function clog2-based counter width helper.
- Sub-module frame_bank (1 bank: registered array, one write port, one combinational read port), instantiated twice.
- FSM and counters stay in the top module.

Test Plan:
- ImageWidth=4: write 16 pixels 1..16 back-to-back, out_ready=1, down_done pulsed 3 cycles after the last transfer -> conv_clear once, out_data 1..16 on consecutive cycles, out_last on 16, frame_done coincident with down_done.
- Hold out_ready=0 for 5 cycles at pixel 7 -> out_data stays 7, out_valid stays 1, no pixel lost or duplicated; the stream resumes with 7 then 8.
- Write frame A (1..16) then frame B (101..116) immediately; B's writes continue during A streaming. A 3rd write while both banks are full -> wr_ready=0 and data ignored. Output: A stream, DRAIN, conv_clear, then B stream.
- Last write of bank 1 in the same cycle as the last read transfer of bank 0 -> full flags end as {1,0}→ read bank 1 next, wr_ready=1.
- Assert res_n=1 at pixel 9 mid-stream -> next cycle all outputs at reset values; a subsequent new frame of 16 pixels streams correctly from pixel 0.
- down_done=1 pulsed during STREAM -> ignored. FSM remains in DRAIN after the last pixel until a later down_done, with frame_done emitted only then.
